// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmitter and its later siblings.
//   uart_tx_state_t : frame state encoding (PARITY is used only when the
//                     parity feature is compiled in)
//   UART_IDLE_LEVEL : line level between frames
//   frame_len()     : number of bit periods in one frame; multiply by the
//                     clock divider to get the frame length in clocks
// ----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_tx_state_t;

   localparam logic UART_IDLE_LEVEL = 1'b1;

   function automatic int unsigned frame_len(input int unsigned data_bits,
                                             input int unsigned stop_bits,
                                             input int unsigned p);
      return 1 + data_bits + p + stop_bits;
   endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// ----------------------------------------------------------------------------
// uart_tx_param_if
// Word handshake between a byte source and the UART transmitter.
//   data_in : word to transmit, sampled when valid && ready
//   valid   : source has a word
//   ready   : transmitter can take a word this cycle
// Modports: master = byte source, slave = transmitter.
// ----------------------------------------------------------------------------
interface uart_tx_param_if #(
   parameter int unsigned DATA_BITS = 8
) ();

   logic [DATA_BITS-1:0] data_in;
   logic                 valid;
   logic                 ready;

   modport master (output data_in, output valid, input ready);
   modport slave  (input data_in, input valid, output ready);

endinterface

// File: rtl/uart_baud_cnt.sv
// ----------------------------------------------------------------------------
// uart_baud_cnt
// Bit-period counter: counts 0..CLK_DIV-1 and wraps; bit_end marks the last
// clock of each bit period.
//   clk     : system clock
//   rst_n   : synchronous reset, active low
//   clr     : synchronous clear, holds the count at 0
//   bit_end : high while the count equals CLK_DIV-1
// ----------------------------------------------------------------------------
module uart_baud_cnt #(
   parameter int unsigned CLK_DIV = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic bit_end
);

   localparam logic [15:0] CNT_LAST = 16'(CLK_DIV - 1);

   logic [15:0] cnt_q, cnt_d;

   assign bit_end = (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d = cnt_q + 16'd1;
      if (clr || bit_end) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_tx_param.sv
// ----------------------------------------------------------------------------
// uart_tx_param
// Parametrised UART transmitter. One word per valid/ready handshake is sent as
// start bit, DATA_BITS data bits, optional parity bit and STOP_BITS stop bits,
// each bit held for CLK_DIV clocks. A word accepted in the last clock of the
// last stop bit starts the next frame with no idle gap.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit
// (even, or odd when PARITY_ODD=1) after the last data bit.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous reset, active low
//   bus   : slave side of the word handshake (data_in, valid, ready)
//   tx    : serial line, idles high
//   busy  : a frame is in progress
//   done  : one-clock pulse in the last clock of the last stop bit
// ----------------------------------------------------------------------------
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int unsigned CLK_DIV    = 16,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned LSB_FIRST  = 1,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic           clk,
   input  logic           rst_n,
   uart_tx_param_if.slave bus,
   output logic           tx,
   output logic           busy,
   output logic           done
);

   if (CLK_DIV < 2 || CLK_DIV > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
       STOP_BITS < 1 || STOP_BITS > 2 || LSB_FIRST > 1 || PARITY_ODD > 1)
   begin : g_bad_param
      $error("uart_tx_param: parameter out of legal range");
   end

   localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

   uart_tx_state_t       state_q, state_d;
   logic [DATA_BITS-1:0] sh_q, sh_d;
   logic [3:0]           idx_q, idx_d;
   logic                 tx_q, tx_d;
   logic                 en_q;     // low in the cycles right after a reset edge
`ifdef UART_TX_PARITY_EN
   logic                 par_q, par_d;
`endif

   logic                 bit_end;
   logic                 last_stop;
   logic                 accept;
   logic                 next_bit;
   logic [DATA_BITS-1:0] sh_next;

   uart_baud_cnt #(.CLK_DIV(CLK_DIV)) u_baud (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (state_q == IDLE),
      .bit_end(bit_end)
   );

   // The shift register always presents the next bit to send at one end.
   assign next_bit = (LSB_FIRST != 0) ? sh_q[0] : sh_q[DATA_BITS-1];
   assign sh_next  = (LSB_FIRST != 0) ? (sh_q >> 1) : (sh_q << 1);

   assign last_stop = (state_q == STOP) && bit_end && (idx_q == LAST_STOP);
   assign bus.ready = en_q && ((state_q == IDLE) || last_stop);
   assign accept    = bus.valid && bus.ready;

   assign tx   = tx_q;
   assign busy = (state_q != IDLE);
   assign done = last_stop;

   always_comb begin
      // NOTE: every variable gets a default here so no path infers a latch.
      state_d = state_q;
      sh_d    = sh_q;
      idx_d   = idx_q;
      tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif

      case (state_q)
         IDLE: tx_d = UART_IDLE_LEVEL;
         START: begin
            if (bit_end) begin
               state_d = DATA;
               tx_d    = next_bit;
               sh_d    = sh_next;
               idx_d   = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (idx_q == LAST_DATA) begin
                  idx_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
                  tx_d    = par_q;
`else
                  state_d = STOP;
                  tx_d    = UART_IDLE_LEVEL;
`endif
               end else begin
                  idx_d = idx_q + 4'd1;
                  tx_d  = next_bit;
                  sh_d  = sh_next;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               state_d = STOP;
               tx_d    = UART_IDLE_LEVEL;
               idx_d   = '0;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               if (idx_q == LAST_STOP) begin
                  state_d = IDLE;
                  tx_d    = UART_IDLE_LEVEL;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = UART_IDLE_LEVEL;
         end
      endcase

      // Accept is only possible in IDLE or the last stop clock; it overrides
      // the return to IDLE so back-to-back frames have no gap.
      if (accept) begin
         state_d = START;
         tx_d    = 1'b0;
         sh_d    = bus.data_in;
         idx_d   = '0;
`ifdef UART_TX_PARITY_EN
         par_d   = (^bus.data_in) ^ (PARITY_ODD != 0);
`endif
      end
   end

   // NOTE: reset is synchronous; the whole datapath is cleared with the FSM
   // so an aborted frame leaves nothing behind.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sh_q    <= '0;
         idx_q   <= '0;
         tx_q    <= UART_IDLE_LEVEL;
         en_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments for all state so every flop
         // samples the values from before this edge.
         state_q <= state_d;
         sh_q    <= sh_d;
         idx_q   <= idx_d;
         tx_q    <= tx_d;
         en_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_param.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_param
// Directed bench for uart_tx_param with CLK_DIV=4, DATA_BITS=8.
//   dut 0 : LSB first, 1 stop bit, even parity (when compiled in)
//   dut 1 : MSB first, 2 stop bits
//   dut 2 : LSB first, 1 stop bit, odd parity (when compiled in)
// Frames are written as bit strings in line order (first bit on the left).
// ----------------------------------------------------------------------------
module tb_uart_tx_param;

   localparam int unsigned CLK_DIV = 4;

`ifdef UART_TX_PARITY_EN
   localparam int NB   = 11;
   localparam int NB_B = 12;
   localparam logic [15:0] F_A5     = 16'b01010010101;
   localparam logic [15:0] F_A5_ODD = 16'b01010010111;
   localparam logic [15:0] F_00     = 16'b00000000001;
   localparam logic [15:0] F_FF     = 16'b01111111101;
   localparam logic [15:0] F_5A     = 16'b00101101001;
   localparam logic [15:0] F_3C     = 16'b00011110001;
   localparam logic [15:0] F_80_MSB = 16'b010000000111;
`else
   localparam int NB   = 10;
   localparam int NB_B = 11;
   localparam logic [15:0] F_A5     = 16'b0101001011;
   localparam logic [15:0] F_A5_ODD = 16'b0101001011;
   localparam logic [15:0] F_00     = 16'b0000000001;
   localparam logic [15:0] F_FF     = 16'b0111111111;
   localparam logic [15:0] F_5A     = 16'b0010110101;
   localparam logic [15:0] F_3C     = 16'b0001111001;
   localparam logic [15:0] F_80_MSB = 16'b01000000011;
`endif

   logic clk;
   logic rst_n;
   logic tx_o   [3];
   logic busy_o [3];
   logic done_o [3];
   int   done_cnt [3];
   int   n_assert;
   int   n_fail;

   uart_tx_param_if #(.DATA_BITS(8)) bus_a ();
   uart_tx_param_if #(.DATA_BITS(8)) bus_b ();
   uart_tx_param_if #(.DATA_BITS(8)) bus_c ();

   uart_tx_param #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .STOP_BITS(1),
                   .LSB_FIRST(1), .PARITY_ODD(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a),
      .tx(tx_o[0]), .busy(busy_o[0]), .done(done_o[0]));

   uart_tx_param #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .STOP_BITS(2),
                   .LSB_FIRST(0), .PARITY_ODD(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b),
      .tx(tx_o[1]), .busy(busy_o[1]), .done(done_o[1]));

   uart_tx_param #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .STOP_BITS(1),
                   .LSB_FIRST(1), .PARITY_ODD(1)) dut_c (
      .clk(clk), .rst_n(rst_n), .bus(bus_c),
      .tx(tx_o[2]), .busy(busy_o[2]), .done(done_o[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      for (int w = 0; w < 3; w++) done_cnt[w] = 0;
   end

   always @(negedge clk) begin
      for (int w = 0; w < 3; w++)
         if (done_o[w] === 1'b1) done_cnt[w] = done_cnt[w] + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // {tx, ready, busy, done} of the selected DUT
   function automatic logic [3:0] obs(input int w);
      case (w)
         0:       return {tx_o[0], bus_a.ready, busy_o[0], done_o[0]};
         1:       return {tx_o[1], bus_b.ready, busy_o[1], done_o[1]};
         default: return {tx_o[2], bus_c.ready, busy_o[2], done_o[2]};
      endcase
   endfunction

   task automatic drive(input int w, input logic v, input logic [7:0] d);
      case (w)
         0:       begin bus_a.valid = v; bus_a.data_in = d; end
         1:       begin bus_b.valid = v; bus_b.data_in = d; end
         default: begin bus_c.valid = v; bus_c.data_in = d; end
      endcase
   endtask

   task automatic check_idle(input int w, input string tag,
                             input logic exp_ready);
      logic [3:0] o;
      o = obs(w);
      check({tag, " tx"},    o[3], 1'b1);
      check({tag, " ready"}, o[2], exp_ready);
      check({tag, " busy"},  o[1], 1'b0);
      check({tag, " done"},  o[0], 1'b0);
   endtask

   // Called at a negedge with the DUT idle; accept happens at the next edge.
   task automatic send(input int w, input logic [7:0] d, input string tag);
      logic [3:0] o;
      o = obs(w);
      check({tag, " ready before accept"}, o[2], 1'b1);
      drive(w, 1'b1, d);
      @(negedge clk);
      drive(w, 1'b0, d);
   endtask

   // Called at the negedge of frame cycle 1; checks cycles 1..ncheck.
   // valid is pulsed (data 0xFF) during cycles p_lo..p_hi when p_hi > 0.
   task automatic expect_frame(input int w, input logic [15:0] bits,
                               input int nbits, input int ncheck,
                               input int p_lo, input int p_hi,
                               input string tag);
      logic [3:0] o;
      logic       last;
      for (int c = 1; c <= ncheck; c++) begin
         if (c > 1) @(negedge clk);
         o    = obs(w);
         last = (c == nbits * CLK_DIV);
         check($sformatf("%s tx c%0d", tag, c),    o[3],
               bits[nbits - 1 - (c - 1) / CLK_DIV]);
         check($sformatf("%s ready c%0d", tag, c), o[2], last);
         check($sformatf("%s busy c%0d", tag, c),  o[1], 1'b1);
         check($sformatf("%s done c%0d", tag, c),  o[0], last);
         if (p_hi > 0) drive(w, (c >= p_lo) && (c <= p_hi), 8'hFF);
      end
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      drive(0, 1'b0, 8'h00);
      drive(1, 1'b0, 8'h00);
      drive(2, 1'b0, 8'h00);

      // Reset state
      repeat (3) @(negedge clk);
      for (int w = 0; w < 3; w++) check_idle(w, $sformatf("reset d%0d", w), 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      for (int w = 0; w < 3; w++) check_idle(w, $sformatf("post-reset d%0d", w), 1'b1);

      // 1. Single frame 0xA5
      send(0, 8'hA5, "t1");
      expect_frame(0, F_A5, NB, NB * CLK_DIV, 0, 0, "t1");
      @(negedge clk);
      check_idle(0, "t1 after", 1'b1);

      // 2. Back-to-back 0x00 then 0xFF with valid held high
      check("t2 ready", obs(0) >> 2 & 4'h1, 1'b1);
      drive(0, 1'b1, 8'h00);
      @(negedge clk);
      drive(0, 1'b1, 8'hFF);
      expect_frame(0, F_00, NB, NB * CLK_DIV, 0, 0, "t2a");
      @(negedge clk);
      drive(0, 1'b0, 8'hFF);
      expect_frame(0, F_FF, NB, NB * CLK_DIV, 0, 0, "t2b");
      @(negedge clk);
      check_idle(0, "t2 after", 1'b1);

      // 3. Parity sense: even on dut 0 (frame above), odd on dut 2
      send(2, 8'hA5, "t3");
      expect_frame(2, F_A5_ODD, NB, NB * CLK_DIV, 0, 0, "t3");
      @(negedge clk);
      check_idle(2, "t3 after", 1'b1);

      // 4. MSB first, two stop bits, 0x80
      send(1, 8'h80, "t4");
      expect_frame(1, F_80_MSB, NB_B, NB_B * CLK_DIV, 0, 0, "t4");
      @(negedge clk);
      check_idle(1, "t4 after", 1'b1);

      // 5. Reset mid-frame at cycle 15, then a clean 0x3C frame
      send(0, 8'h5A, "t5");
      expect_frame(0, F_5A, NB, 14, 0, 0, "t5a");
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check_idle(0, "t5 in reset", 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      check_idle(0, "t5 released", 1'b1);
      send(0, 8'h3C, "t5");
      expect_frame(0, F_3C, NB, NB * CLK_DIV, 0, 0, "t5b");
      @(negedge clk);
      check_idle(0, "t5 after", 1'b1);

      // 6. valid pulsed during cycles 5..20 of an active frame
      send(0, 8'hA5, "t6");
      expect_frame(0, F_A5, NB, NB * CLK_DIV, 5, 20, "t6");
      repeat (3) @(negedge clk);
      check_idle(0, "t6 after", 1'b1);

      // done pulse totals: no pulse for the aborted frame or the hold-off
      check("done count d0", done_cnt[0], 5);
      check("done count d1", done_cnt[1], 1);
      check("done count d2", done_cnt[2], 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter: serialises one word per valid/ready handshake into a frame of start bit, data bits, optional parity and stop bits.
- Each bit is held for a programmable number of clocks.
- Successor to the fixed-pattern free-running transmitter: accepts arbitrary data, supports back-to-back frames and reports completion.
- Sits between a byte source (FIFO, register file, test pattern generator) and the board's serial line.

Parameters:
CLK_DIV, 16, clocks per bit; legal range 2..65535
DATA_BITS, 8, data bits per frame; legal range 5..9
STOP_BITS, 1, stop bits per frame; 1 or 2
LSB_FIRST, 1, 1 = bit 0 sent first; 0 = MSB first
PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd

Ports:
clk  in  1  system clock; all logic on its rising edge
rst_n  in  1  synchronous reset, active low
data_in  in  DATA_BITS  word to transmit; sampled on accept
valid  in  1  data_in is valid
ready  out  1  block can accept a word this cycle
tx  out  1  serial output; idle level 1
busy  out  1  a frame is in progress
done  out  1  one-cycle pulse in the final clock of the last stop bit

Behaviour:
- Reset: one clock, synchronous, active low; rst_n=0 at a rising edge forces all state at that edge.
  - Outputs while rst_n=0: tx=1, ready=0, busy=0, done=0; state IDLE.
  - ready=1 from the first edge with rst_n=1.
- Accept: occurs in any cycle where valid&&ready is high at the rising edge.
  - data_in is copied into the shift register at that edge.
  - data_in/valid are don't-care at all other times.
- States: IDLE, START, DATA, PARITY (only when compiled in), STOP.
- Bit timing: 16-bit counter cnt counts 0..CLK_DIV-1 per bit and wraps at CLK_DIV-1; that wrap is the bit boundary.
  - A bit-index counter tracks DATA positions and STOP positions.
- Transitions:
  - IDLE -> START on accept.
  - START -> DATA after CLK_DIV clocks.
  - DATA -> PARITY (or -> STOP) after DATA_BITS bits.
  - PARITY -> STOP after 1 bit.
  - STOP -> IDLE after STOP_BITS bits, unless a new accept occurs in that last cycle (then -> START).
- tx is registered.
  - tx=0 from the edge after accept; start bit lasts exactly CLK_DIV clocks.
  - Data bits are shifted out LSB- or MSB-first per LSB_FIRST.
  - Stop bits: tx=1.
- Frame length: (1+DATA_BITS+P+STOP_BITS)*CLK_DIV clocks, where P=1 if parity is compiled in, else 0.
- ready is asserted only:
  - in IDLE, or
  - in the last clock of the last stop bit (same cycle as done).
  - Accepting in that last clock gives gapless back-to-back frames: the next start bit follows the stop bit with zero idle clocks.
- busy=1 in all states except IDLE. busy stays 1 across a back-to-back transition.
- done: exactly one pulse per completed frame. No pulse for a frame aborted by reset.
- Reset mid-frame: tx=1 at the reset edge; the frame is abandoned; no partial stop bit is completed.
- valid held high continuously: one frame is sent per accept; the word is never duplicated.
- valid dropping before ready: no accept; no state change.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted after the last data bit.
  - Parity bit = XOR of the latched data, inverted when PARITY_ODD=1.
  - Frame grows by CLK_DIV clocks.
- Undefined:
  - No PARITY state, no parity logic.
  - PARITY_ODD is ignored.
  - Frame = start + data + stop.

Decomposition:
- Shared package uart_pkg:
  - state enum type uart_tx_state_t (IDLE, START, DATA, PARITY, STOP).
  - constant UART_IDLE_LEVEL = 1'b1.
  - function frame_len(DATA_BITS, STOP_BITS, P), returning clocks per bit-count, for benches.
- One sub-module uart_baud_cnt:
  - Parametrised CLK_DIV counter with synchronous clear.
  - Outputs a bit_end pulse at count CLK_DIV-1.
  - Reused later by the receiver.

Test Plan:
Common setup: CLK_DIV=4, DATA_BITS=8, STOP_BITS=1, LSB_FIRST=1, parity off, unless stated otherwise.
1. Single frame: data_in=0xA5 accepted at cycle 0 -> tx from cycle 1, each value for 4 clocks: 0,1,0,1,0,0,1,0,1,1; done at cycle 40; ready=0 during cycles 1..39; tx=1 afterwards.
2. Back-to-back: valid held high with 0x00 then 0xFF -> second start bit begins at cycle 41 with no idle clock; exactly two done pulses, 40 clocks apart.
3. Parity: UART_TX_PARITY_EN defined, PARITY_ODD=0, data 0xA5 -> parity bit 0 for 4 clocks before stop; frame 44 clocks. Repeat with PARITY_ODD=1 -> parity bit 1.
4. MSB-first and two stop bits: LSB_FIRST=0, STOP_BITS=2, data 0x80 -> tx 0,1,0,0,0,0,0,0,0,1,1; frame 44 clocks.
5. Reset mid-frame: rst_n=0 for 1 clock at cycle 15 -> tx=1, ready=0, busy=0 at the edge; no done; a new accept 0x3C after release produces a clean full frame.
6. Handshake hold-off: valid pulsed during cycles 5..20 of an active frame -> no accept, tx sequence unaffected, no extra done.
